// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues credit-limited word fetches and buffers responses for decode.
// Optional FETCH_PERF_CNT_EN adds delivered-word and stall-cycle counters.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        misalign_err
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    localparam int          PW  = $clog2(FIFO_DEPTH);
    localparam int          CW  = 3;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] out_q, out_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [PW-1:0] wr_q, wr_d;
    logic          mis_q, mis_d;
    logic [31:0]   fifo_instr_q [FIFO_DEPTH];
    logic [31:0]   fifo_pc_q    [FIFO_DEPTH];

    logic          credit;
    logic          accept;
    logic          push;
    logic          pop;
    logic [31:0]   redirect_aligned;

    assign redirect_aligned = {redirect_pc[31:2], 2'b00};
    assign credit           = ({1'b0, cnt_q} + {1'b0, out_q}) < 4'(FIFO_DEPTH);
    // Gated by rst_n so no request is ever shown while reset is asserted.
    assign imem_req_valid   = rst_n && !redirect_valid && credit;
    assign imem_req_addr    = pc_q;
    assign accept           = imem_req_valid && imem_req_ready;
    assign push             = imem_rsp_valid && (drop_q == '0) && !redirect_valid;
    assign instr_valid      = (cnt_q != '0);
    assign pop              = instr_valid && instr_ready && !redirect_valid;
    assign instr            = instr_valid ? fifo_instr_q[rd_q] : NOP;
    assign instr_pc         = instr_valid ? fifo_pc_q[rd_q] : 32'h0;
    assign misalign_err     = mis_q;

    always_comb begin
        pc_d      = pc_q;
        resp_pc_d = resp_pc_q;
        out_d     = out_q + CW'(accept) - CW'(imem_rsp_valid);
        drop_d    = drop_q;
        cnt_d     = cnt_q + CW'(push) - CW'(pop);
        rd_d      = pop  ? rd_q + PW'(1) : rd_q;
        wr_d      = push ? wr_q + PW'(1) : wr_q;
        mis_d     = mis_q;
        if (accept) begin
            pc_d = pc_q + 32'd4;
        end
        if (push) begin
            resp_pc_d = resp_pc_q + 32'd4;
        end
        if (imem_rsp_valid && (drop_q != '0)) begin
            drop_d = drop_q - CW'(1);
        end
        if (redirect_valid) begin
            pc_d      = redirect_aligned;
            resp_pc_d = redirect_aligned;
            cnt_d     = '0;
            rd_d      = '0;
            wr_d      = '0;
            // Every request still in flight belongs to the old path; earlier drops are a subset of them.
            drop_d    = out_q - CW'(imem_rsp_valid);
            mis_d     = mis_q | (redirect_pc[1:0] != 2'b00);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            resp_pc_q <= RESET_PC;
            out_q     <= '0;
            drop_q    <= '0;
            cnt_q     <= '0;
            rd_q      <= '0;
            wr_q      <= '0;
            mis_q     <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            resp_pc_q <= resp_pc_d;
            out_q     <= out_d;
            drop_q    <= drop_d;
            cnt_q     <= cnt_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            mis_q     <= mis_d;
        end
    end

    // Storage needs no reset: entries are only read while the count marks them valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr_q[wr_q] <= imem_rsp_data;
            fifo_pc_q[wr_q]    <= resp_pc_q;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_q + 32'(pop);
            stall_cnt_q <= stall_cnt_q + 32'(!instr_valid && !redirect_valid);
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule
